// File: rtl/median_pkg.sv
// Shared definitions for the median-filter block: FSM encoding, window geometry
// and default image dimensions.
package median_pkg;

    localparam int IMG_W_DEF   = 64;
    localparam int IMG_H_DEF   = 64;

    localparam int WIN_SIZE    = 9;
    localparam int CENTRE_SLOT = 4;

    // Encoding matches the controller so state can be compared across blocks.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    localparam logic [3:0] LAST_SLOT = 4'(WIN_SIZE - 1);

endpackage

// File: rtl/win_addr_gen.sv
// Maps a window centre and slot index to a linear pixel address, flagging
// neighbours that fall outside the image as padding.
module win_addr_gen
    import median_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 6,
    parameter int ADDR_W = 12
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] addr,
    output logic              pad
);

    logic [ROW_W:0] r_off, r_ext;
    logic [COL_W:0] c_off, c_ext;
    logic           r_pad, c_pad, k_pad;

    // Offsets are one bit wider than the index so -1 and +1 never wrap silently.
    always_comb begin
        r_off = '0;
        c_off = '0;
        case (k)
            4'd0, 4'd1, 4'd2: r_off = '1;
            4'd6, 4'd7, 4'd8: r_off = (ROW_W+1)'(1);
            default:          r_off = '0;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: c_off = '1;
            4'd2, 4'd5, 4'd8: c_off = (COL_W+1)'(1);
            default:          c_off = '0;
        endcase
    end

    assign r_ext = {1'b0, row} + r_off;
    assign c_ext = {1'b0, col} + c_off;

    // A set MSB means either -1 or one past the index range; both are outside.
    assign r_pad = r_ext[ROW_W] | (r_ext >= (ROW_W+1)'(IMG_H));
    assign c_pad = c_ext[COL_W] | (c_ext >= (COL_W+1)'(IMG_W));
    assign k_pad = (k > LAST_SLOT);
    assign pad   = r_pad | c_pad | k_pad;

    assign addr = pad ? '0
                      : ADDR_W'(r_ext[ROW_W-1:0]) * ADDR_W'(IMG_W) + ADDR_W'(c_ext[COL_W-1:0]);

endmodule

// File: rtl/window_fetch.sv
// Fetches the zero-padded 3x3 neighbourhood of a pixel from a 1-cycle-latency
// RAM and presents it in parallel with a single-cycle valid pulse.
module window_fetch
    import median_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int DATA_W = 8,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 6,
    parameter int ADDR_W = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [ROW_W-1:0]             row,
    input  logic [COL_W-1:0]             col,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_rd_data,
    output logic                         busy,
    output logic                         win_valid,
    output logic [WIN_SIZE*DATA_W-1:0]   win_data,
    output logic                         err
);

    state_t                            state;
    logic [ROW_W-1:0]                  row_q;
    logic [COL_W-1:0]                  col_q;
    logic [3:0]                        k;
    logic [ADDR_W-1:0]                 gen_addr;
    logic                              gen_pad;
    logic                              in_range;
    logic                              cap_vld, cap_pad;
    logic [3:0]                        cap_slot;
    logic [WIN_SIZE-1:0][DATA_W-1:0]   win_q;

    win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .row  (row_q),
        .col  (col_q),
        .k    (k),
        .addr (gen_addr),
        .pad  (gen_pad)
    );

    assign in_range  = ({1'b0, row} < (ROW_W+1)'(IMG_H)) && ({1'b0, col} < (COL_W+1)'(IMG_W));
    assign mem_rd_en = (state == FETCH) && !gen_pad;
    assign mem_addr  = mem_rd_en ? gen_addr : '0;
    assign win_data  = win_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            k         <= '0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            err       <= 1'b0;
            cap_vld   <= 1'b0;
            cap_pad   <= 1'b0;
            cap_slot  <= '0;
            win_q     <= '0;
        end else begin
            win_valid <= 1'b0;
            err       <= 1'b0;

            // Slot tag travels one stage behind the address to meet the read data.
            cap_vld  <= (state == FETCH);
            cap_pad  <= gen_pad;
            cap_slot <= k;
            if (cap_vld)
                win_q[cap_slot] <= cap_pad ? '0 : mem_rd_data;

            case (state)
                IDLE: begin
                    if (load) begin
                        if (in_range) begin
                            row_q <= row;
                            col_q <= col;
                            k     <= '0;
                            busy  <= 1'b1;
                            state <= FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (k == LAST_SLOT)
                        state <= DRAIN;
                    else
                        k <= k + 4'd1;
                end
                DRAIN: begin
                    win_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_fetch.sv
// Randomized scoreboard bench for window_fetch on a 4x4 image with mem[a]=a+16.
module tb_window_fetch;

    localparam int W = 4, H = 4, DW = 8, RW = 3, CW = 3, AW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               load = 1'b0;
    logic [RW-1:0]      row = '0;
    logic [CW-1:0]      col = '0;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_rd_data = '0;
    logic               busy, win_valid, err;
    logic [9*DW-1:0]    win_data;

    typedef struct {
        int          cyc;
        logic [71:0] data;
    } ev_t;

    ev_t         win_exp[$];
    ev_t         err_exp[$];
    ev_t         rd_exp[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          acc_e = -100;
    int          free_e = 0;
    logic [71:0] cur_win = '0;

    window_fetch #(
        .IMG_W(W), .IMG_H(H), .DATA_W(DW), .ROW_W(RW), .COL_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .row(row), .col(col),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .win_valid(win_valid), .win_data(win_data), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM: 1-cycle latency, junk on the bus when not read.
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? ({4'b0, mem_addr} + 8'd16) : 8'($urandom);

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [71:0] model_win(int r0, int c0);
        logic [71:0] w;
        w = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                int r = r0 + dy;
                int c = c0 + dx;
                if (r >= 0 && r < H && c >= 0 && c < W)
                    w[(3*(dy+1)+(dx+1))*DW +: DW] = DW'(r*W + c + 16);
            end
        return w;
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle load; the model decides acceptance from edge timing alone.
    task automatic do_load(int r, int c);
        int  e;
        ev_t ev;
        @(negedge clk);
        load = 1'b1;
        row  = RW'(r);
        col  = CW'(c);
        e    = cyc + 1;
        if (e >= free_e) begin
            if (r < H && c < W) begin
                acc_e   = e;
                free_e  = e + 12;
                cur_win = model_win(r, c);
                ev.cyc  = e + 10;
                ev.data = cur_win;
                win_exp.push_back(ev);
                for (int k = 0; k < 9; k++) begin
                    int rr = r + k/3 - 1;
                    int cc = c + k%3 - 1;
                    if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                        ev.cyc  = e + k;
                        ev.data = 72'(rr*W + cc);
                        rd_exp.push_back(ev);
                    end
                end
            end else begin
                ev.cyc  = e;
                ev.data = cur_win;
                err_exp.push_back(ev);
            end
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", {busy, win_valid, err, mem_rd_en, mem_addr, win_data}, '0);
        win_exp.delete();
        err_exp.delete();
        rd_exp.delete();
        acc_e   = -100;
        free_e  = 0;
        cur_win = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: compares every observable output each cycle against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs", {busy, win_valid, err, mem_rd_en, mem_addr, win_data}, '0);
        end else begin
            chk("busy", busy, (acc_e >= 0 && cyc >= acc_e && cyc <= acc_e + 10));
            if (rd_exp.size() > 0 && rd_exp[0].cyc == cyc) begin
                chk("mem_rd_en", mem_rd_en, 1);
                chk("mem_addr", mem_addr, rd_exp[0].data);
                void'(rd_exp.pop_front());
            end else begin
                chk("mem_rd_en_idle", mem_rd_en, 0);
                chk("mem_addr_idle", mem_addr, 0);
            end
            if (win_exp.size() > 0 && win_exp[0].cyc == cyc) begin
                chk("win_valid", win_valid, 1);
                chk("win_data", win_data, win_exp[0].data);
                void'(win_exp.pop_front());
            end else begin
                chk("win_valid_idle", win_valid, 0);
            end
            if (err_exp.size() > 0 && err_exp[0].cyc == cyc) begin
                chk("err", err, 1);
                chk("win_data_held", win_data, err_exp[0].data);
                void'(err_exp.pop_front());
            end else begin
                chk("err_idle", err, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        idle(3);
        rst = 1'b1;

        do_load(1, 1); idle(12);
        do_load(0, 0); idle(12);
        do_load(3, 3); idle(12);

        // Load during fetch is ignored; load in the IDLE cycle after DONE is accepted.
        do_load(1, 2); idle(3);
        do_load(2, 1); idle(5);
        do_load(2, 2); idle(12);

        do_load(4, 0); idle(2);
        do_load(0, 4); idle(2);

        do_load(2, 1); idle(3);
        do_reset();
        do_load(2, 2); idle(12);

        for (int i = 0; i < 60; i++) begin
            int r, c;
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            do_load(r, c);
            if ($urandom_range(0, 19) == 0) begin
                idle($urandom_range(0, 8));
                do_reset();
            end else begin
                idle($urandom_range(0, 13));
            end
        end

        idle(15);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
